// File: rtl/ram_access_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ram_access_arbiter: round-robin two-port access sequencer for a single-  |
// | port synchronous RAM. Optional zero fill via macro RAM_INIT_CLEAR_EN.    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module ram_access_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    ACCESS  = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

`ifdef RAM_INIT_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
  localparam logic   BUSY_RST    = 1'b1;
`else
  localparam state_t RESET_STATE = IDLE;
  localparam logic   BUSY_RST    = 1'b0;
`endif

  state_t state, state_nxt;

  logic              last_grant, last_grant_nxt;
  logic              cur_port, cur_port_nxt;
  logic              cur_we, cur_we_nxt;
  logic              gnt0_nxt, gnt1_nxt;
  logic              rvalid0_nxt, rvalid1_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              busy_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_data_nxt;
  logic              ram_wren_nxt;

`ifdef RAM_INIT_CLEAR_EN
  // One extra bit so the MSB flags that every address has been written.
  logic [ADDR_W:0]   clr_idx, clr_idx_nxt;
`endif

  // Winner of the current IDLE cycle: on contention, the port not served last.
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign pick      = (req0 && req1) ? ~last_grant : req1;
  assign sel_we    = pick ? we1    : we0;
  assign sel_addr  = pick ? addr1  : addr0;
  assign sel_wdata = pick ? wdata1 : wdata0;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cur_port_nxt   = cur_port;
    cur_we_nxt     = cur_we;
    gnt0_nxt       = 1'b0;
    gnt1_nxt       = 1'b0;
    rvalid0_nxt    = 1'b0;
    rvalid1_nxt    = 1'b0;
    rdata_nxt      = rdata;
    busy_nxt       = busy;
    ram_addr_nxt   = ram_addr;
    ram_data_nxt   = ram_data;
    ram_wren_nxt   = 1'b0;
`ifdef RAM_INIT_CLEAR_EN
    clr_idx_nxt    = clr_idx;
`endif

    case (state)
      CLEAR: begin
`ifdef RAM_INIT_CLEAR_EN
        if (clr_idx[ADDR_W]) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          ram_wren_nxt = 1'b1;
          ram_addr_nxt = clr_idx[ADDR_W-1:0];
          ram_data_nxt = '0;
          clr_idx_nxt  = clr_idx + 1'b1;
        end
`else
        state_nxt = IDLE;
`endif
      end

      IDLE: begin
        if (req0 || req1) begin
          gnt0_nxt       = ~pick;
          gnt1_nxt       = pick;
          ram_addr_nxt   = sel_addr;
          ram_data_nxt   = sel_wdata;
          ram_wren_nxt   = sel_we;
          last_grant_nxt = pick;
          cur_port_nxt   = pick;
          cur_we_nxt     = sel_we;
          state_nxt      = ACCESS;
        end
      end

      // The RAM samples address/data at the end of this cycle.
      ACCESS: begin
        state_nxt = cur_we ? IDLE : RD_WAIT;
      end

      RD_WAIT: begin
        rdata_nxt   = ram_q;
        rvalid0_nxt = ~cur_port;
        rvalid1_nxt = cur_port;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      cur_we     <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata      <= '0;
      busy       <= BUSY_RST;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
`ifdef RAM_INIT_CLEAR_EN
      clr_idx    <= '0;
`endif
    end else begin
      last_grant <= last_grant_nxt;
      cur_port   <= cur_port_nxt;
      cur_we     <= cur_we_nxt;
      gnt0       <= gnt0_nxt;
      gnt1       <= gnt1_nxt;
      rvalid0    <= rvalid0_nxt;
      rvalid1    <= rvalid1_nxt;
      rdata      <= rdata_nxt;
      busy       <= busy_nxt;
      ram_addr   <= ram_addr_nxt;
      ram_data   <= ram_data_nxt;
      ram_wren   <= ram_wren_nxt;
`ifdef RAM_INIT_CLEAR_EN
      clr_idx    <= clr_idx_nxt;
`endif
    end
  end

  a_rvalid_onehot: assert property (@(posedge CLOCK_50) disable iff (!resetn)
    !(rvalid0 && rvalid1));

  a_gnt_onehot: assert property (@(posedge CLOCK_50) disable iff (!resetn)
    !(gnt0 && gnt1));

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_ram_access_arbiter: table vectors, corner sequences and random traffic |
// | against a transaction-level model. Honours RAM_INIT_CLEAR_EN. Rev 1.0     |
// +---------------------------------------------------------------------------+
module tb_ram_access_arbiter;

`ifdef RAM_INIT_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren;
  logic [7:0] rdata, ram_data, ram_q;
  logic [4:0] ram_addr;

  // Board RAM: registered address, q valid one clock after sampling.
  logic [7:0] ram_mem [32] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  always #10 clk = ~clk;

  ram_access_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .CLOCK_50(clk), .resetn(resetn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] mem_m [32] = '{default: 8'h00};
  bit         last_m = 1'b1;
  logic [7:0] rdata_m = 8'h00;

  typedef struct {
    bit         port;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},    {gnt0, gnt1}, 0);
    chk({tag, "_rvalid"}, {rvalid0, rvalid1}, 0);
    chk({tag, "_rdata"},  rdata, 0);
    chk({tag, "_ram"},    {ram_addr, ram_data, ram_wren}, 0);
    chk({tag, "_busy"},   busy, CLR);
  endtask

  task automatic wait_gnt(output int w);
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (!(gnt0 || gnt1) && w < 40);
  endtask

  // Zero-fill sequence after reset release; any pending request must stay ungranted.
  task automatic check_clear();
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      chk("clr_busy", busy, 1);
      chk("clr_wren", ram_wren, 1);
      chk("clr_addr", ram_addr, i);
      chk("clr_data", ram_data, 0);
      chk("clr_nognt", {gnt0, gnt1}, 0);
    end
    @(posedge clk); #1;
    chk("clr_done_wren", ram_wren, 0);
    chk("clr_done_busy", busy, 0);
    for (int i = 0; i < 32; i++) mem_m[i] = 8'h00;
  endtask

  // One transaction from an idle arbiter; grant expected on the very next edge.
  task automatic do_txn(input bit p, input bit we, input logic [4:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    int w;
    if (!p) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    wait_gnt(w);
    chk("gnt_lat",   w, 1);
    chk("gnt",       p ? gnt1 : gnt0, 1);
    chk("gnt_other", p ? gnt0 : gnt1, 0);
    chk("ram_wren",  ram_wren, we);
    chk("ram_addr",  ram_addr, a);
    if (we) chk("ram_data", ram_data, d);
    req0 = 1'b0; req1 = 1'b0;
    last_m = p;
    if (we) begin
      mem_m[a] = d;
      @(posedge clk); #1;
      chk("wren_drop", ram_wren, 0);
    end else begin
      @(posedge clk); #1;
      chk("rv_early", {rvalid0, rvalid1}, 0);
      @(posedge clk); #1;
      chk("rvalid",       p ? rvalid1 : rvalid0, 1);
      chk("rvalid_other", p ? rvalid0 : rvalid1, 0);
      chk("rdata",        rdata, exp);
      rdata_m = exp;
    end
  endtask

  initial begin
    vec_t tbl [9];
    int   w;
    bit   expp;
    int   k, free_edge, rv_edge;
    bit   rv_port, p, e_g0, e_g1, e_rv0, e_rv1, e_we;
    logic [7:0] rv_data, e_data;
    logic [4:0] e_addr;

    tbl[0] = '{1'b0, 1'b0, 5'd5,  8'h00, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 5'd3,  8'hA5, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 5'd3,  8'h00, 8'hA5};
    tbl[3] = '{1'b1, 1'b1, 5'd31, 8'hFF, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'hFF};
    tbl[5] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h00};
    tbl[6] = '{1'b0, 1'b1, 5'd0,  8'h3C, 8'h00};
    tbl[7] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h3C};
    tbl[8] = '{1'b0, 1'b0, 5'd3,  8'h00, 8'hA5};

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");

`ifdef RAM_INIT_CLEAR_EN
    @(negedge clk) resetn = 1'b1;
    check_clear();
`else
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd9; wdata0 = 8'h5A;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    chk("rel_gnt0", gnt0, 1);
    chk("rel_busy", busy, 0);
    chk("rel_ram",  {ram_addr, ram_data, ram_wren}, {5'd9, 8'h5A, 1'b1});
    req0 = 1'b0;
    mem_m[9] = 8'h5A; last_m = 1'b0;
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 9; i++)
      do_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    // Both ports hold read requests: grants must alternate.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd31;
    expp = ~last_m;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(w);
      chk("rr_gnt1", gnt1, expp);
      chk("rr_gnt0", gnt0, !expp);
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (g == 3) begin req0 = 1'b0; req1 = 1'b0; end
      chk("rr_rvalid", {rvalid1, rvalid0}, expp ? 2'b10 : 2'b01);
      chk("rr_rdata",  rdata, mem_m[expp ? 31 : 3]);
      rdata_m = mem_m[expp ? 31 : 3];
      last_m = expp;
      expp = ~expp;
    end

    // Random traffic against a transaction-level model of grant timing and memory.
    k = 0; free_edge = 0; rv_edge = -1; rv_port = 1'b0; rv_data = 8'h00;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      k++;
      e_g0 = 1'b0; e_g1 = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
      if (k >= free_edge && (req0 || req1)) begin
        p = (req0 && req1) ? ~last_m : req1;
        last_m = p;
        e_g0 = ~p; e_g1 = p;
        e_we = p ? we1 : we0;
        e_addr = p ? addr1 : addr0;
        e_data = p ? wdata1 : wdata0;
        if (e_we) begin
          mem_m[e_addr] = e_data;
          free_edge = k + 2;
        end else begin
          rv_edge = k + 2; rv_port = p; rv_data = mem_m[e_addr];
          free_edge = k + 3;
        end
      end
      e_rv0 = (k == rv_edge) && !rv_port;
      e_rv1 = (k == rv_edge) && rv_port;
      if (k == rv_edge) rdata_m = rv_data;
      #1;
      chk("rnd_gnt",    {gnt0, gnt1}, {e_g0, e_g1});
      chk("rnd_rvalid", {rvalid0, rvalid1}, {e_rv0, e_rv1});
      chk("rnd_rdata",  rdata, rdata_m);
      chk("rnd_wren",   ram_wren, e_we);
      if (e_g0 || e_g1) begin
        chk("rnd_addr", ram_addr, e_addr);
        if (e_we) chk("rnd_data", ram_data, e_data);
      end
      if (e_g0) req0 = 1'b0;
      else if (!req0 && ($urandom % 3 == 0)) begin
        req0 = 1'b1; we0 = $urandom % 2; addr0 = 5'($urandom_range(0, 31));
        wdata0 = 8'($urandom);
      end
      if (e_g1) req1 = 1'b0;
      else if (!req1 && ($urandom % 3 == 0)) begin
        req1 = 1'b1; we1 = $urandom % 2; addr1 = 5'($urandom_range(0, 31));
        wdata1 = 8'($urandom);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_rdata", rdata, rdata_m);

    // Reset during RD_WAIT drops the read; a request pending at release waits for any clear.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
    wait_gnt(w);
    chk("mid_gnt0", gnt0, 1);
    req0 = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    chk_reset_outputs("mid_hold");
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd4;
    last_m = 1'b1; rdata_m = 8'h00;
    @(negedge clk) resetn = 1'b1;
`ifdef RAM_INIT_CLEAR_EN
    check_clear();
`endif
    do_txn(1'b1, 1'b0, 5'd4, 8'h00, mem_m[4]);
    do_txn(1'b0, 1'b0, 5'd31, 8'h00, mem_m[31]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
